osd_overlay: RTL and testbench

OSD_OVERLAY -- requirements
Module: osd_overlay

---
 rtl/osd_overlay.sv | 190 +++++++++++++++++++
 tb/tb_osd_overlay.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/osd_overlay.sv
// ---------------------------------------------------------------------------
// osd_overlay
//
// Mixes a 256 x 64 monochrome on-screen-display bitmap into scan-doubled
// video. Line and frame lengths are measured from the incoming syncs so the
// window is centred on whatever timing the scan doubler produces. Inside
// the window a set pixel paints white and a clear pixel dims the video to
// 50%; outside the window the video passes through untouched. Syncs are
// only delayed, never altered.
//
// Ports
//   clk_x2            doubled-rate video clock, rising edge
//   reset             asynchronous, active-high
//   osd_enable        OSD visible request, sampled at each frame start
//   wr_en/addr/data   bitmap byte write port (bit n = pixel row n of a column)
//   hs_in, vs_in      active-low syncs from the scan doubler
//   r_in, g_in, b_in  video from the scan doubler
//   hs_out, vs_out    syncs delayed by three clocks
//   r_out..b_out      mixed video, three clocks behind the input
// ---------------------------------------------------------------------------
module osd_overlay #(
    parameter int DATA_W = 6
) (
    input  logic              clk_x2,
    input  logic              reset,
    input  logic              osd_enable,
    input  logic              wr_en,
    input  logic [10:0]       wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] g_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              hs_out,
    output logic              vs_out,
    output logic [DATA_W-1:0] r_out,
    output logic [DATA_W-1:0] g_out,
    output logic [DATA_W-1:0] b_out
);

    function automatic logic [10:0] sat_inc_h(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc_v(input logic [9:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

    // Overlay mix: white for a set pixel, half brightness for a clear one.
    function automatic logic [DATA_W-1:0] mix_px(input logic [DATA_W-1:0] c,
                                                 input logic in_w,
                                                 input logic px);
        logic [DATA_W-1:0] m;
        if (!in_w)
            m = c;
        else if (px)
            m = '1;
        else
            m = {1'b0, c[DATA_W-1:1]};
        return m;
    endfunction

    logic        hs_d, vs_d;
    logic        line_start, frame_start;
    logic [10:0] hcnt, h_total;
    logic [9:0]  vcnt, v_total;
    logic        en_l;

    assign line_start  = hs_d & ~hs_in;
    assign frame_start = vs_d & ~vs_in;

    // Timing measurement. A coincident line start and frame start must leave
    // vcnt at zero, so the frame-start branch is checked first.
    always_ff @(posedge clk_x2 or posedge reset) begin
        if (reset) begin
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            hcnt    <= '0;
            h_total <= '0;
            vcnt    <= '0;
            v_total <= '0;
            en_l    <= 1'b0;
        end else begin
            hs_d <= hs_in;
            vs_d <= vs_in;
            if (line_start) begin
                hcnt    <= '0;
                h_total <= hcnt;
            end else begin
                hcnt <= sat_inc_h(hcnt);
            end
            if (frame_start) begin
                vcnt    <= '0;
                v_total <= vcnt;
                en_l    <= osd_enable;
            end else if (line_start) begin
                vcnt <= sat_inc_v(vcnt);
            end
        end
    end

    // Window placement. The end bounds carry one extra bit so that a window
    // near the top of the counter range does not wrap.
    logic [10:0] h_start;
    logic [9:0]  v_start;
    logic [11:0] h_end;
    logic [10:0] v_end;
    logic        win_dis, h_hit, v_hit, in_win;
    logic [7:0]  x_off;
    logic [5:0]  y_off;

    assign h_start = {1'b0, h_total[10:1]} - 11'd128;
    assign v_start = {1'b0, v_total[9:1]} - 10'd32;
    assign h_end   = {1'b0, h_start} + 12'd256;
    assign v_end   = {1'b0, v_start} + 11'd64;
    assign win_dis = (h_total < 11'd256) || (v_total < 10'd64);
    assign h_hit   = (hcnt >= h_start) && ({1'b0, hcnt} < h_end);
    assign v_hit   = (vcnt >= v_start) && ({1'b0, vcnt} < v_end);
    assign in_win  = en_l && !win_dis && h_hit && v_hit;
    // Only the low bits of the offsets are needed inside the window.
    assign x_off   = hcnt[7:0] - h_start[7:0];
    assign y_off   = vcnt[5:0] - v_start[5:0];

    logic              vld_p0, vld_p1;
    logic [10:0]       addr_p0;
    logic [2:0]        bit_p0, bit_p1;
    logic [DATA_W-1:0] r_p0, g_p0, b_p0, r_p1, g_p1, b_p1;
    logic              hs_p0, vs_p0, hs_p1, vs_p1;
    logic [7:0]        rd_p1;
    logic [7:0]        bitmap [0:2047];

    // Bitmap RAM: not cleared by reset; a same-cycle read of the address
    // being written returns the previous contents.
    always_ff @(posedge clk_x2) begin
        if (wr_en)
            bitmap[wr_addr] <= wr_data;
        rd_p1 <= bitmap[addr_p0];
    end

    always_ff @(posedge clk_x2 or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
            bit_p0  <= '0;
            r_p0    <= '0;
            g_p0    <= '0;
            b_p0    <= '0;
            hs_p0   <= 1'b0;
            vs_p0   <= 1'b0;
            vld_p1  <= 1'b0;
            bit_p1  <= '0;
            r_p1    <= '0;
            g_p1    <= '0;
            b_p1    <= '0;
            hs_p1   <= 1'b0;
            vs_p1   <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            r_out   <= '0;
            g_out   <= '0;
            b_out   <= '0;
        end else begin
            // Stage 1: window decision, bitmap address, video and syncs
            vld_p0  <= in_win;
            addr_p0 <= {y_off[5:3], x_off};
            bit_p0  <= y_off[2:0];
            r_p0    <= r_in;
            g_p0    <= g_in;
            b_p0    <= b_in;
            hs_p0   <= hs_in;
            vs_p0   <= vs_in;
            // Stage 2: bitmap byte arrives in rd_p1
            vld_p1  <= vld_p0;
            bit_p1  <= bit_p0;
            r_p1    <= r_p0;
            g_p1    <= g_p0;
            b_p1    <= b_p0;
            hs_p1   <= hs_p0;
            vs_p1   <= vs_p0;
            // Stage 3: mixed output register
            hs_out  <= hs_p1;
            vs_out  <= vs_p1;
            r_out   <= mix_px(r_p1, vld_p1, rd_p1[bit_p1]);
            g_out   <= mix_px(g_p1, vld_p1, rd_p1[bit_p1]);
            b_out   <= mix_px(b_p1, vld_p1, rd_p1[bit_p1]);
        end
    end

endmodule

// File: tb/tb_osd_overlay.sv
// ---------------------------------------------------------------------------
// tb_osd_overlay
//
// Directed bench for osd_overlay. Frames are 70 lines; most lines are 16
// clocks, while the lines of interest (and the line before each, which sets
// h_total) are long. With 300-clock lines h_total=299 and v_total=69, giving
// a window at hcnt 21..276 and vcnt 2..65. On a line the pixel driven at
// in-line cycle c has hcnt=c-1, so x = c-22, and appears on the outputs
// three clocks later (capture slot c+2). Video per cycle: r=c, g=2A, b=3F-c.
// ---------------------------------------------------------------------------
module tb_osd_overlay;

    logic       clk_x2 = 1'b0;
    logic       reset;
    logic       osd_enable;
    logic       wr_en;
    logic [10:0] wr_addr;
    logic [7:0] wr_data;
    logic       hs_in, vs_in;
    logic [5:0] r_in, g_in, b_in;
    logic       hs_out, vs_out;
    logic [5:0] r_out, g_out, b_out;

    osd_overlay dut (
        .clk_x2    (clk_x2),
        .reset     (reset),
        .osd_enable(osd_enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    always #5 clk_x2 = ~clk_x2;

    int total = 0;
    int bad   = 0;

    logic [5:0] cap_r [0:511];
    logic [5:0] cap_g [0:511];
    logic [5:0] cap_b [0:511];
    logic       cap_hs [0:511];
    logic       cap_vs [0:511];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pixel driven at cycle c of the last line is in capture slot c+2.
    task automatic chk_px(input string tag, input int c,
                          input logic [5:0] er, input logic [5:0] eg, input logic [5:0] eb);
        chk({tag, ".r"}, 8'(cap_r[c+2]), 8'(er));
        chk({tag, ".g"}, 8'(cap_g[c+2]), 8'(eg));
        chk({tag, ".b"}, 8'(cap_b[c+2]), 8'(eb));
    endtask

    task automatic write_byte(input logic [10:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk_x2); #1;
        wr_en   = 1'b0;
    endtask

    task automatic drive_line(input int len, input bit fstart, input int wr_c,
                              input logic [10:0] wa, input logic [7:0] wd, input int rst_c);
        for (int c = 0; c < len; c++) begin
            hs_in   = (c < 4) ? 1'b0 : 1'b1;
            vs_in   = fstart ? 1'b0 : 1'b1;
            r_in    = 6'(c);
            g_in    = 6'h2A;
            b_in    = 6'h3F - 6'(c);
            wr_en   = (c == wr_c);
            wr_addr = wa;
            wr_data = wd;
            @(posedge clk_x2); #1;
            cap_r[c]  = r_out;
            cap_g[c]  = g_out;
            cap_b[c]  = b_out;
            cap_hs[c] = hs_out;
            cap_vs[c] = vs_out;
            if (c == rst_c) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_async_hs", 8'(hs_out), 8'h00);
                chk("rst_async_vs", 8'(vs_out), 8'h00);
                chk("rst_async_r", 8'(r_out), 8'h00);
                chk("rst_async_g", 8'(g_out), 8'h00);
                chk("rst_async_b", 8'(b_out), 8'h00);
                #1 reset = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    function automatic bit is_long(input int l);
        return l inside {0, 1, 2, 3, 25, 26, 27, 28, 29, 32, 33, 59, 60, 64, 65, 66, 69};
    endfunction

    task automatic check_line(input int fr, input int l);
        if (fr == 1 && l == 26) chk_px("f1_unmeasured", 27, 6'h1B, 6'h2A, 6'h24);
        if (fr == 2 && l == 0) begin
            chk("hs_lag_before", 8'(cap_hs[1]), 8'h01);
            chk("hs_lag_fall", 8'(cap_hs[2]), 8'h00);
            chk("hs_lag_low_end", 8'(cap_hs[5]), 8'h00);
            chk("hs_lag_rise", 8'(cap_hs[6]), 8'h01);
            chk("vs_lag_before", 8'(cap_vs[1]), 8'h01);
            chk("vs_lag_fall", 8'(cap_vs[2]), 8'h00);
        end
        if (fr == 2 && l == 1) chk_px("f2_above_win", 22, 6'h16, 6'h2A, 6'h29);
        if (fr == 2 && l == 2) begin
            chk_px("f2_left_out", 21, 6'h15, 6'h2A, 6'h2A);
            chk_px("f2_x0_y0_dim", 22, 6'h0B, 6'h15, 6'h14);
            chk_px("f2_x255_dim", 277, 6'h0A, 6'h15, 6'h15);
            chk_px("f2_right_out", 278, 6'h16, 6'h2A, 6'h29);
        end
        if (fr == 2 && l == 26) chk_px("f2_y24_set", 27, 6'h3F, 6'h3F, 6'h3F);
        if (fr == 2 && l == 27) chk_px("f2_y25_clear", 27, 6'h0D, 6'h15, 6'h12);
        if (fr == 2 && l == 28) chk_px("f2_collide_old", 27, 6'h0D, 6'h15, 6'h12);
        if (fr == 2 && l == 29) chk_px("f2_collide_new", 27, 6'h3F, 6'h3F, 6'h3F);
        if (fr == 2 && l == 33) chk_px("f2_y31_set", 27, 6'h3F, 6'h3F, 6'h3F);
        if (fr == 2 && l == 65) chk_px("f2_y63_dim", 22, 6'h0B, 6'h15, 6'h14);
        if (fr == 2 && l == 66) chk_px("f2_below_win", 22, 6'h16, 6'h2A, 6'h29);
        if (fr == 3 && l == 60) chk_px("f3_defer_keep", 22, 6'h0B, 6'h15, 6'h14);
        if (fr == 4 && l == 2) chk_px("f4_disabled", 22, 6'h16, 6'h2A, 6'h29);
        if (fr == 4 && l == 26) chk_px("f4_late_enable", 27, 6'h1B, 6'h2A, 6'h24);
        if (fr == 5 && l == 2) chk_px("f5_overlay_on", 22, 6'h0B, 6'h15, 6'h14);
        if (fr == 5 && l == 26) chk_px("f5_after_reset", 27, 6'h1B, 6'h2A, 6'h24);
        if (fr == 6 && l == 26) chk_px("f6_short_lines", 27, 6'h1B, 6'h2A, 6'h24);
    endtask

    task automatic run_frame(input int fr, input int long_len);
        for (int l = 0; l < 70; l++) begin
            int len, wc, rc;
            len = is_long(l) ? long_len : 16;
            wc  = (fr == 2 && l == 28) ? 28 : -1;
            rc  = (fr == 5 && l == 3) ? 100 : -1;
            if (fr == 3 && l == 50) osd_enable = 1'b0;
            if (fr == 4 && l == 10) osd_enable = 1'b1;
            drive_line(len, (l == 0), wc, 11'd773, 8'hFF, rc);
            check_line(fr, l);
        end
    endtask

    initial begin
        reset      = 1'b1;
        osd_enable = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        hs_in      = 1'b1;
        vs_in      = 1'b1;
        r_in       = 6'h2A;
        g_in       = 6'h2A;
        b_in       = 6'h2A;
        repeat (3) @(posedge clk_x2);
        #1;
        chk("reset_hs", 8'(hs_out), 8'h00);
        chk("reset_vs", 8'(vs_out), 8'h00);
        chk("reset_r", 8'(r_out), 8'h00);
        chk("reset_g", 8'(g_out), 8'h00);
        chk("reset_b", 8'(b_out), 8'h00);
        reset = 1'b0;

        write_byte(11'd0, 8'h00);
        write_byte(11'd255, 8'h00);
        write_byte(11'd773, 8'h81);
        write_byte(11'd1792, 8'h00);
        repeat (4) @(posedge clk_x2);
        #1;

        osd_enable = 1'b1;
        run_frame(1, 300);
        run_frame(2, 300);
        run_frame(3, 300);
        run_frame(4, 300);
        run_frame(5, 300);
        run_frame(6, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
